// File: rtl/usb_capture_framer.sv
// usb_capture_framer: turns the UTMI receive stream into 32-bit capture
// records (LINE / SOP / DATA / EOP).
// Records are buffered in a small FIFO because the receive path cannot
// be stalled. When the FIFO is full, records are dropped and counted.
module usb_capture_framer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [7:0]  utmi_data_in_i,
  input  logic        utmi_rxvalid_i,
  input  logic        utmi_rxactive_i,
  input  logic        utmi_rxerror_i,
  input  logic [1:0]  utmi_linestate_i,
  output logic        outport_valid_o,
  output logic [31:0] outport_data_o,
  input  logic        outport_ready_i,
  output logic [15:0] drop_count_o,
  output logic        active_o,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RX    = 2'd1,
    S_FLUSH = 2'd2,
    S_EOP   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [27:0]  ts_q, ts_d;
  logic [1:0]   ll_q, ll_d;
  logic         ll_valid_q, ll_valid_d;
  logic         ignore_q, ignore_d;
  logic [23:0]  acc_q, acc_d;
  logic [1:0]   acc_cnt_q, acc_cnt_d;
  logic [15:0]  pkt_cnt_q, pkt_cnt_d;
  logic         err_q, err_d;
  logic         drop_q, drop_d;
  logic [15:0]  drop_cnt_q, drop_cnt_d;
  logic         active_q, active_d;
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]  mem_q [FIFO_DEPTH];

  logic [AW:0]  fifo_count;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pop;
  logic         wr_req;
  logic         wr_en;
  logic [31:0]  wr_data;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);

  // Output handshake: a record transfers on a cycle where valid and ready are
  // both high; while valid is high and ready is low, the data word is held.
  assign outport_valid_o = ~fifo_empty;
  assign outport_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign pop             = outport_valid_o & outport_ready_i;
  assign wr_en           = wr_req & ~fifo_full;

  assign drop_count_o = drop_cnt_q;
  assign active_o     = active_q;
  assign dbg_state_o  = state_q;

  // Next-state: framing state machine, record generation and drop accounting.
  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q + 28'd1;
    ll_d       = ll_q;
    ll_valid_d = ll_valid_q;
    ignore_d   = ignore_q;
    acc_d      = acc_q;
    acc_cnt_d  = acc_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_d      = err_q;
    drop_d     = drop_q;
    drop_cnt_d = drop_cnt_q;
    wr_req     = 1'b0;
    wr_data    = 32'h0;

    // While disabled, forget the last logged state so re-enabling logs one LINE.
    if (!enable_i) ll_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ignore_q) begin
          // Riding out a packet that started while capture was not possible.
          ignore_d = utmi_rxactive_i;
        end else if (utmi_rxactive_i) begin
          if (enable_i) begin
            wr_req    = 1'b1;
            wr_data   = {2'b01, 2'b00, ts_q};
            acc_d     = 24'h0;
            acc_cnt_d = 2'd0;
            pkt_cnt_d = 16'h0;
            err_d     = 1'b0;
            drop_d    = 1'b0;
            state_d   = S_RX;
          end else begin
            ignore_d = 1'b1;
          end
        end else if (enable_i && (!ll_valid_q || (utmi_linestate_i != ll_q))) begin
          wr_req     = 1'b1;
          wr_data    = {2'b00, utmi_linestate_i, ts_q};
          ll_d       = utmi_linestate_i;
          ll_valid_d = 1'b1;
        end
      end

      S_RX: begin
        if (utmi_rxerror_i) err_d = 1'b1;
        if (utmi_rxvalid_i) begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          case (acc_cnt_q)
            2'd0: begin
              acc_d[7:0] = utmi_data_in_i;
              acc_cnt_d  = 2'd1;
            end
            2'd1: begin
              acc_d[15:8] = utmi_data_in_i;
              acc_cnt_d   = 2'd2;
            end
            default: begin
              wr_req    = 1'b1;
              wr_data   = {2'b10, 2'd3, 4'h0, utmi_data_in_i, acc_q[15:0]};
              acc_d     = 24'h0;
              acc_cnt_d = 2'd0;
            end
          endcase
        end
        if (!utmi_rxactive_i) begin
          state_d = (acc_cnt_d != 2'd0) ? S_FLUSH : S_EOP;
        end
      end

      S_FLUSH: begin
        wr_req    = 1'b1;
        wr_data   = {2'b10, acc_cnt_q, 4'h0, acc_q};
        acc_d     = 24'h0;
        acc_cnt_d = 2'd0;
        state_d   = S_EOP;
      end

      S_EOP: begin
        // A packet beginning while EOP is stuck behind a full FIFO is ignored.
        ignore_d = utmi_rxactive_i;
        if (!fifo_full) begin
          wr_req     = 1'b1;
          wr_data    = {2'b11, err_q, drop_q, 12'h0, pkt_cnt_q};
          ll_d       = utmi_linestate_i;
          ll_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A record that finds the FIFO full is discarded and accounted for.
    if (wr_req && fifo_full) begin
      drop_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    active_d = (state_d != S_IDLE);
  end

  // FIFO pointer arithmetic.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ts_q       <= 28'h0;
      ll_q       <= 2'b00;
      ll_valid_q <= 1'b0;
      ignore_q   <= 1'b0;
      acc_q      <= 24'h0;
      acc_cnt_q  <= 2'd0;
      pkt_cnt_q  <= 16'h0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= 16'h0;
      active_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      ll_q       <= ll_d;
      ll_valid_q <= ll_valid_d;
      ignore_q   <= ignore_d;
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
      active_q   <= active_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Record storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule
